retire_trace_buffer: RTL and testbench
======================================

RETIRE_TRACE_BUFFER -- requirements
Module: retire_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of trace entries; power of two, >= 2.
REQ-002 SHALL have parameter CNT_W, default 16: width of the overflow counter.
REQ-003 SHALL have parameter FREEZE_ON_EBREAK, default 1: when 1, capturing an EBREAK freezes capture.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port ret_valid, input, 1: one instruction retired this cycle.
REQ-007 SHALL have port ret_pc, input, 32: PC of the retired instruction.
REQ-008 SHALL have port ret_instr, input, 32: encoding of the retired instruction.
REQ-009 SHALL have port ret_wdata, input, 32: rd write-back value, 0 if none.
REQ-010 SHALL have port out_valid, output, 1: head entry available.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts the head entry.
REQ-012 SHALL have ports out_pc, out_instr and out_wdata, output, 32 each: head-entry fields.
REQ-013 SHALL have port out_class, output, 4: head-entry instruction class.
REQ-014 SHALL have port count, output, $clog2(DEPTH)+1: number of occupied entries.
REQ-015 SHALL have port overflow_cnt, output, CNT_W: number of dropped retirements.
REQ-016 SHALL have port frozen, output, 1: capture halted.
REQ-017 SHALL have port unfreeze, input, 1: pulse that resumes capture.

Function
REQ-018 SHALL classify ret_instr combinationally using the riscvibe_pkg opcode constants:
- 0x00000013 -> 12 (NOP); NOP is checked first.
- OP -> 0, OP_IMM -> 1, LOAD -> 2, STORE -> 3, BRANCH -> 4.
- JAL -> 5, JALR -> 6, LUI -> 7, AUIPC -> 8.
- SYSTEM with funct3 = 0: instr[31:20] = 0 -> 9 (ECALL); instr[31:20] = 1 -> 10 (EBREAK).
- FENCE -> 11.
- Anything else -> 15.
REQ-019 SHALL push {pc, instr, wdata, class} at the tail when ret_valid is 1, frozen is 0, and the buffer is either not full or popping in the same cycle.
REQ-020 SHALL pop the head when out_valid and out_ready are both 1.
REQ-021 SHALL make a pushed entry visible at out_* exactly one cycle after the push (no bypass).
REQ-022 SHALL drive out_valid = (count != 0), with no combinational path from out_ready to out_valid.
REQ-023 SHALL hold out_* stable while out_valid is 1 and out_ready is 0.
REQ-024 SHALL drive out_pc, out_instr, out_wdata and out_class to 0 when empty.
REQ-025 SHALL update count as follows on simultaneous push and pop: count unchanged, both pointers advance.
REQ-026 SHALL, when full with ret_valid = 1, frozen = 0 and no pop, drop the retirement and increment overflow_cnt.
REQ-027 SHALL saturate overflow_cnt at all-ones.
REQ-028 SHALL wrap the read and write pointers modulo DEPTH.
REQ-029 SHALL, with FREEZE_ON_EBREAK = 1, store an EBREAK entry that is pushed and set frozen to 1 on the following cycle.
REQ-030 SHALL ignore ret_valid while frozen: nothing is stored and overflow_cnt is not incremented.
REQ-031 SHALL allow pops to continue normally while frozen.
REQ-032 SHALL clear frozen on the cycle after unfreeze = 1.
REQ-033 SHALL give priority to setting frozen when unfreeze and an EBREAK push occur in the same cycle, leaving frozen = 1.
REQ-034 SHALL NOT set frozen for an EBREAK that is dropped because the buffer is full.

Reset
REQ-035 SHALL, while rst is asserted, asynchronously force:
- read and write pointers to 0;
- count to 0 and out_valid to 0;
- overflow_cnt to 0 and frozen to 0.
REQ-036 SHALL leave storage contents unreset; outputs still read 0 because the buffer is empty.
REQ-037 SHALL discard all entries when rst is asserted mid-operation, including during an active handshake.

Configuration
REQ-038 SHALL, when TRACE_NOP_FILTER_EN is defined, neither store nor count as overflow any retirement with ret_instr = 0x00000013.
REQ-039 SHALL, when TRACE_NOP_FILTER_EN is undefined, store NOPs as class 12 like any other retirement.

Verification
REQ-040 SHALL cover: reset, then push pc=0x100, instr=0x00500093 -> next cycle out_valid=1, out_class=1, out_pc=0x100, count=1.
REQ-041 SHALL cover: DEPTH=4, out_ready=0, push 6 retirements -> count=4, overflow_cnt=2, head pc = first pushed pc.
REQ-042 SHALL cover: full buffer with push and pop in the same cycle -> count stays 4, new entry stored, overflow_cnt unchanged.
REQ-043 SHALL cover: push 0x00100073 then 3 more retirements -> frozen=1, count=1, overflow_cnt=0; unfreeze pulse -> frozen=0 next cycle, capture resumes.
REQ-044 SHALL cover: push 0x00000013 -> with the macro defined, count stays 0; without it, out_class=12.
REQ-045 SHALL cover: assert rst mid-stream with 3 entries -> count=0, out_valid=0, out_pc=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/retire_trace_buffer.sv
// Retirement trace FIFO: classifies each retired instruction, buffers it for a consumer,
// counts drops on overflow, and can freeze on EBREAK. Optional macro: TRACE_NOP_FILTER_EN.
module retire_trace_buffer #(
  parameter int unsigned DEPTH            = 16,
  parameter int unsigned CNT_W            = 16,
  parameter int unsigned FREEZE_ON_EBREAK = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ret_valid,
  input  logic [31:0]                ret_pc,
  input  logic [31:0]                ret_instr,
  input  logic [31:0]                ret_wdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_wdata,
  output logic [3:0]                 out_class,
  output logic [$clog2(DEPTH):0]     count,
  output logic [CNT_W-1:0]           overflow_cnt,
  output logic                       frozen,
  input  logic                       unfreeze
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam bit          FRZ_EN = (FREEZE_ON_EBREAK != 0);

  // Opcode values mirror the riscvibe_pkg constants so this file stands alone.
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP_ENC = 32'h0000_0013;

  localparam logic [3:0] CLS_OP     = 4'd0;
  localparam logic [3:0] CLS_OP_IMM = 4'd1;
  localparam logic [3:0] CLS_LOAD   = 4'd2;
  localparam logic [3:0] CLS_STORE  = 4'd3;
  localparam logic [3:0] CLS_BRANCH = 4'd4;
  localparam logic [3:0] CLS_JAL    = 4'd5;
  localparam logic [3:0] CLS_JALR   = 4'd6;
  localparam logic [3:0] CLS_LUI    = 4'd7;
  localparam logic [3:0] CLS_AUIPC  = 4'd8;
  localparam logic [3:0] CLS_ECALL  = 4'd9;
  localparam logic [3:0] CLS_EBREAK = 4'd10;
  localparam logic [3:0] CLS_FENCE  = 4'd11;
  localparam logic [3:0] CLS_NOP    = 4'd12;
  localparam logic [3:0] CLS_OTHER  = 4'd15;

  function automatic logic [3:0] classify(input logic [31:0] instr);
    logic [3:0] cls;
    cls = CLS_OTHER;
    if (instr == NOP_ENC) begin
      cls = CLS_NOP;
    end else begin
      unique case (instr[6:0])
        OPC_OP:     cls = CLS_OP;
        OPC_OP_IMM: cls = CLS_OP_IMM;
        OPC_LOAD:   cls = CLS_LOAD;
        OPC_STORE:  cls = CLS_STORE;
        OPC_BRANCH: cls = CLS_BRANCH;
        OPC_JAL:    cls = CLS_JAL;
        OPC_JALR:   cls = CLS_JALR;
        OPC_LUI:    cls = CLS_LUI;
        OPC_AUIPC:  cls = CLS_AUIPC;
        OPC_FENCE:  cls = CLS_FENCE;
        OPC_SYSTEM: begin
          if (instr[14:12] == 3'b000 && instr[31:20] == 12'd0)
            cls = CLS_ECALL;
          else if (instr[14:12] == 3'b000 && instr[31:20] == 12'd1)
            cls = CLS_EBREAK;
          else
            cls = CLS_OTHER;
        end
        default:    cls = CLS_OTHER;
      endcase
    end
    return cls;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (val == {CNT_W{1'b1}}) ? val : val + 1'b1;
  endfunction

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   wdata_mem [DEPTH];
  logic [3:0]    cls_mem   [DEPTH];

  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CNT_W-1:0] ovf_q;
  logic             frozen_q;

  logic [3:0] ret_class;
  logic       nop_drop;
  logic       capture;
  logic       full;
  logic       empty;
  logic       pop;
  logic       push;
  logic       drop;
  logic       freeze_set;

  assign ret_class = classify(ret_instr);

`ifdef TRACE_NOP_FILTER_EN
  assign nop_drop = (ret_instr == NOP_ENC);
`else
  assign nop_drop = 1'b0;
`endif

  // Qualify the retirement, then decide between store, drop or ignore.
  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  assign capture    = ret_valid && !frozen_q && !nop_drop;
  assign pop        = !empty && out_ready;
  assign push       = capture && (!full || pop);
  assign drop       = capture && full && !pop;
  assign freeze_set = FRZ_EN && push && (ret_class == CLS_EBREAK);

  // Storage write: data path carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= ret_pc;
      instr_mem[wr_ptr_q] <= ret_instr;
      wdata_mem[wr_ptr_q] <= ret_wdata;
      cls_mem[wr_ptr_q]   <= ret_class;
    end
  end

  // Control state: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= '0;
    end else if (drop) begin
      ovf_q <= sat_inc(ovf_q);
    end
  end

  // An EBREAK being stored wins over a simultaneous unfreeze request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frozen_q <= 1'b0;
    end else if (freeze_set) begin
      frozen_q <= 1'b1;
    end else if (unfreeze) begin
      frozen_q <= 1'b0;
    end
  end

  always_comb begin
    out_pc    = '0;
    out_instr = '0;
    out_wdata = '0;
    out_class = '0;
    if (!empty) begin
      out_pc    = pc_mem[rd_ptr_q];
      out_instr = instr_mem[rd_ptr_q];
      out_wdata = wdata_mem[rd_ptr_q];
      out_class = cls_mem[rd_ptr_q];
    end
  end

  assign out_valid    = !empty;
  assign count        = count_q;
  assign overflow_cnt = ovf_q;
  assign frozen       = frozen_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer (DEPTH=4, CNT_W=3): classification table plus
// overflow, saturation, freeze, NOP and asynchronous-reset sequences.
module tb_retire_trace_buffer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam logic [31:0] WKEY   = 32'h5a5a_0000;
  localparam logic [31:0] ADDI   = 32'h0050_0093;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic              clk = 1'b0;
  logic              rst;
  logic              ret_valid;
  logic [31:0]       ret_pc, ret_instr, ret_wdata;
  logic              out_valid, out_ready;
  logic [31:0]       out_pc, out_instr, out_wdata;
  logic [3:0]        out_class;
  logic [2:0]        count;
  logic [CNT_W-1:0]  overflow_cnt;
  logic              frozen, unfreeze;

  int n_pass  = 0;
  int n_total = 0;

  retire_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W), .FREEZE_ON_EBREAK(1)) dut (
    .clk(clk), .rst(rst),
    .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr), .ret_wdata(ret_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_wdata(out_wdata), .out_class(out_class),
    .count(count), .overflow_cnt(overflow_cnt), .frozen(frozen), .unfreeze(unfreeze)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        rdy;
    logic        e_vld;
    logic [31:0] e_pc;
    logic [3:0]  e_cls;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                      input logic rdy, input logic unf);
    ret_valid = v;
    ret_pc    = pc;
    ret_instr = instr;
    ret_wdata = pc ^ WKEY;
    out_ready = rdy;
    unfreeze  = unf;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ret_valid = 1'b0; ret_pc = '0; ret_instr = '0; ret_wdata = '0;
    out_ready = 1'b0; unfreeze = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 32'h100, ADDI,         1'b0, 1'b1, 32'h100, 4'd1,  3'd1};
    tbl[1]  = '{1'b1, 32'h104, 32'h003100b3, 1'b1, 1'b1, 32'h104, 4'd0,  3'd1};
    tbl[2]  = '{1'b1, 32'h108, 32'h00012083, 1'b1, 1'b1, 32'h108, 4'd2,  3'd1};
    tbl[3]  = '{1'b1, 32'h10c, 32'h00112023, 1'b1, 1'b1, 32'h10c, 4'd3,  3'd1};
    tbl[4]  = '{1'b1, 32'h110, 32'h00000063, 1'b1, 1'b1, 32'h110, 4'd4,  3'd1};
    tbl[5]  = '{1'b1, 32'h114, 32'h0000006f, 1'b1, 1'b1, 32'h114, 4'd5,  3'd1};
    tbl[6]  = '{1'b1, 32'h118, 32'h000080e7, 1'b1, 1'b1, 32'h118, 4'd6,  3'd1};
    tbl[7]  = '{1'b1, 32'h11c, 32'h000010b7, 1'b1, 1'b1, 32'h11c, 4'd7,  3'd1};
    tbl[8]  = '{1'b1, 32'h120, 32'h00001097, 1'b1, 1'b1, 32'h120, 4'd8,  3'd1};
    tbl[9]  = '{1'b1, 32'h124, 32'h00000073, 1'b1, 1'b1, 32'h124, 4'd9,  3'd1};
    tbl[10] = '{1'b1, 32'h128, 32'h0000000f, 1'b1, 1'b1, 32'h128, 4'd11, 3'd1};
    tbl[11] = '{1'b1, 32'h12c, 32'hffffffff, 1'b1, 1'b1, 32'h12c, 4'd15, 3'd1};
    tbl[12] = '{1'b1, 32'h130, 32'h30200073, 1'b1, 1'b1, 32'h130, 4'd15, 3'd1};
    tbl[13] = '{1'b1, 32'h134, 32'h34011073, 1'b1, 1'b1, 32'h134, 4'd15, 3'd1};
    tbl[14] = '{1'b1, 32'h138, 32'h00100093, 1'b1, 1'b1, 32'h138, 4'd1,  3'd1};
    tbl[15] = '{1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h0,   4'd0,  3'd0};

    // Reset state
    do_reset();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ovf", 32'(overflow_cnt), 32'd0);
    chk("rst_frozen", 32'(frozen), 32'd0);
    chk("rst_pc", out_pc, 32'd0);

    // Classification table: each row pops the previous head and pushes a new one
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].vld, tbl[i].pc, tbl[i].instr, tbl[i].rdy, 1'b0);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_pc", i), out_pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d_class", i), 32'(out_class), 32'(tbl[i].e_cls));
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_instr", i), out_instr, tbl[i].e_vld ? tbl[i].instr : 32'd0);
      chk($sformatf("tbl%0d_wdata", i), out_wdata, tbl[i].e_vld ? (tbl[i].e_pc ^ WKEY) : 32'd0);
    end

    // Asynchronous reset mid-stream with a handshake in progress
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 32'h600 + 32'(i * 4), ADDI, 1'b0, 1'b0);
    chk("mid_count_pre", 32'(count), 32'd3);
    #2;
    out_ready = 1'b1;
    ret_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_valid", 32'(out_valid), 32'd0);
    chk("mid_pc", out_pc, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ret_valid = 1'b0;
    out_ready = 1'b0;
    chk("mid_count_post", 32'(count), 32'd0);

    // Overflow while full, then simultaneous push and pop, then drain through the wrap
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 32'h200 + 32'(i * 4), ADDI, 1'b0, 1'b0);
    chk("ovf_count", 32'(count), 32'd4);
    chk("ovf_cnt", 32'(overflow_cnt), 32'd2);
    chk("ovf_head", out_pc, 32'h200);
    step(1'b1, 32'h300, ADDI, 1'b1, 1'b0);
    chk("pp_count", 32'(count), 32'd4);
    chk("pp_ovf", 32'(overflow_cnt), 32'd2);
    chk("pp_head", out_pc, 32'h204);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("drain1_head", out_pc, 32'h208);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("drain2_head", out_pc, 32'h20c);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("drain3_head", out_pc, 32'h300);
    chk("drain3_wdata", out_wdata, 32'h300 ^ WKEY);
    chk("drain3_count", 32'(count), 32'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("drain4_count", 32'(count), 32'd0);
    chk("drain4_pc", out_pc, 32'd0);

    // Overflow counter saturation
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 32'h700 + 32'(i * 4), ADDI, 1'b0, 1'b0);
    chk("sat_six", 32'(overflow_cnt), 32'd6);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h800 + 32'(i * 4), ADDI, 1'b0, 1'b0);
    chk("sat_max", 32'(overflow_cnt), 32'd7);
    chk("sat_head", out_pc, 32'h700);

    // EBREAK freeze, ignored retirements, unfreeze, priority and drop cases
    do_reset();
    step(1'b1, 32'h400, EBREAK, 1'b0, 1'b0);
    chk("frz_set", 32'(frozen), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h404 + 32'(i * 4), ADDI, 1'b0, 1'b0);
    chk("frz_frozen", 32'(frozen), 32'd1);
    chk("frz_count", 32'(count), 32'd1);
    chk("frz_ovf", 32'(overflow_cnt), 32'd0);
    chk("frz_class", 32'(out_class), 32'd10);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("unfrz", 32'(frozen), 32'd0);
    step(1'b1, 32'h410, ADDI, 1'b0, 1'b0);
    chk("resume_count", 32'(count), 32'd2);
    step(1'b1, 32'h414, EBREAK, 1'b0, 1'b1);
    chk("prio_frozen", 32'(frozen), 32'd1);
    chk("prio_count", 32'(count), 32'd3);
    step(1'b1, 32'h418, ADDI, 1'b1, 1'b0);
    chk("frzpop_count", 32'(count), 32'd2);
    chk("frzpop_head", out_pc, 32'h410);
    chk("frzpop_ovf", 32'(overflow_cnt), 32'd0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("unfrz2", 32'(frozen), 32'd0);
    step(1'b1, 32'h420, ADDI, 1'b0, 1'b0);
    step(1'b1, 32'h424, ADDI, 1'b0, 1'b0);
    chk("fill_count", 32'(count), 32'd4);
    step(1'b1, 32'h428, EBREAK, 1'b0, 1'b0);
    chk("fulleb_frozen", 32'(frozen), 32'd0);
    chk("fulleb_ovf", 32'(overflow_cnt), 32'd1);
    chk("fulleb_count", 32'(count), 32'd4);

    // NOP handling depends on the build option
    do_reset();
    step(1'b1, 32'h500, 32'h0000_0013, 1'b0, 1'b0);
`ifdef TRACE_NOP_FILTER_EN
    chk("nop_count", 32'(count), 32'd0);
    chk("nop_valid", 32'(out_valid), 32'd0);
`else
    chk("nop_count", 32'(count), 32'd1);
    chk("nop_class", 32'(out_class), 32'd12);
    chk("nop_pc", out_pc, 32'h500);
`endif
    chk("nop_ovf", 32'(overflow_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
